// File: rtl/fifo.sv
// Single-clock FIFO with one-cycle registered read data.
// full/empty are decoded from an occupancy counter, so no extra pointer bit is needed to tell them apart.
module fifo #(
  parameter int depth     = 32,
  parameter int width     = 64,
  parameter int ptr_width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam logic [ptr_width:0]   C_DEPTH   = (ptr_width + 1)'(depth);
  localparam logic [ptr_width:0]   C_CNT_0   = (ptr_width + 1)'(0);
  localparam logic [ptr_width:0]   C_CNT_1   = (ptr_width + 1)'(1);
  localparam logic [ptr_width-1:0] C_PTR_0   = (ptr_width)'(0);
  localparam logic [ptr_width-1:0] C_PTR_1   = (ptr_width)'(1);
  localparam logic [width-1:0]     C_DATA_0  = (width)'(0);

  logic [ptr_width-1:0] write_ptr;
  logic [ptr_width-1:0] read_ptr;
  logic [ptr_width:0]   count;
  logic [width-1:0]     r_mem [0:depth-1];

  logic w_wr_en;
  logic w_rd_en;

  // Status decode and accept qualification; a full FIFO rejects writes, an empty one rejects reads.
  always_comb begin
    full    = (count == C_DEPTH);
    empty   = (count == C_CNT_0);
    w_wr_en = we & ~full;
    w_rd_en = re & ~empty;
  end

  // Storage array; left uncleared, stale words become unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (w_wr_en && rst) begin
      r_mem[write_ptr] <= data_in;
    end
  end

  // Pointer, occupancy and registered read-data state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_ptr <= C_PTR_0;
      read_ptr  <= C_PTR_0;
      count     <= C_CNT_0;
      data_out  <= C_DATA_0;
    end else begin
      if (w_wr_en) begin
        write_ptr <= write_ptr + C_PTR_1;
      end else begin
        write_ptr <= write_ptr;
      end

      if (w_rd_en) begin
        read_ptr <= read_ptr + C_PTR_1;
        data_out <= r_mem[read_ptr];
      end else begin
        read_ptr <= read_ptr;
        data_out <= data_out;
      end

      // Simultaneous accepted read and write leave occupancy unchanged.
      case ({w_wr_en, w_rd_en})
        2'b10:   count <= count + C_CNT_1;
        2'b01:   count <= count - C_CNT_1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo: reset, ordering, full/empty boundaries,
// simultaneous read/write and asynchronous reset.
module tb_fifo;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  fifo #(.depth(32), .width(64), .ptr_width(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .re       (re),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    we = 1'b0;
    re = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic fill(input logic [63:0] base, input int n);
    we = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_in = base + 64'(i);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b0; re = 1'b0; data_in = 64'd0;
    #12;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: empty=%b full=%b expected empty=1 full=0", empty, full);
    end
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (dut.count !== 6'd0 || data_out !== 64'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: count=%0d data_out=%h empty=%b full=%b expected 0/0/1/0",
                         dut.count, data_out, empty, full);
    end
  endtask

  task automatic test_basic();
    logic [63:0] exp_v;
    we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 64'(10 * (i + 1));
      tick();
    end
    we = 1'b0;
    n_checks++;
    if (dut.count !== 6'd5 || dut.write_ptr !== 5'd5 || empty !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_write: count=%0d wptr=%0d empty=%b expected 5/5/0",
                         dut.count, dut.write_ptr, empty);
    end
    re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = 64'(10 * (i + 1));
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++; $display("FAIL basic_read%0d: data_out=%h expected %h", i, data_out, exp_v);
      end
    end
    re = 1'b0;
    n_checks++;
    if (dut.count !== 6'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_drained: count=%0d empty=%b expected 0/1", dut.count, empty);
    end
    tick();
    n_checks++;
    if (data_out !== 64'h32) begin
      n_fail++; $display("FAIL basic_hold: data_out=%h expected 32", data_out);
    end
  endtask

  task automatic test_full_wrap();
    logic [63:0] exp_v;
    apply_reset();
    fill(64'hA5A5_0000_0000_0000, 32);
    n_checks++;
    if (full !== 1'b1 || empty !== 1'b0 || dut.count !== 6'd32 || dut.write_ptr !== 5'd0) begin
      n_fail++; $display("FAIL full_flags: full=%b empty=%b count=%0d wptr=%0d expected 1/0/32/0",
                         full, empty, dut.count, dut.write_ptr);
    end
    we = 1'b1; data_in = 64'hDEAD; tick(); we = 1'b0;
    n_checks++;
    if (dut.count !== 6'd32 || dut.write_ptr !== 5'd0) begin
      n_fail++; $display("FAIL full_write_ignored: count=%0d wptr=%0d expected 32/0", dut.count, dut.write_ptr);
    end
    re = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_v = 64'hA5A5_0000_0000_0000 + 64'(i);
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++; $display("FAIL full_read%0d: data_out=%h expected %h", i, data_out, exp_v);
      end
    end
    re = 1'b0;
    n_checks++;
    if (dut.read_ptr !== 5'd0 || empty !== 1'b1 || dut.count !== 6'd0) begin
      n_fail++; $display("FAIL full_drained: rptr=%0d empty=%b count=%0d expected 0/1/0",
                         dut.read_ptr, empty, dut.count);
    end
  endtask

  task automatic test_empty_read();
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (data_out !== 64'hA5A5_0000_0000_001F || dut.read_ptr !== 5'd0 || dut.count !== 6'd0) begin
        n_fail++; $display("FAIL empty_read%0d: data_out=%h rptr=%0d count=%0d expected a5a500000000001f/0/0",
                           i, data_out, dut.read_ptr, dut.count);
      end
    end
    re = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_v;
    // From empty: first edge is write-only, the next three both read and write.
    we = 1'b1; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 64'h100 + 64'(i);
      tick();
      if (i > 0) begin
        exp_v = 64'h100 + 64'(i - 1);
        n_checks++;
        if (data_out !== exp_v) begin
          n_fail++; $display("FAIL b2b_empty_read%0d: data_out=%h expected %h", i, data_out, exp_v);
        end
      end
    end
    we = 1'b0; re = 1'b0;
    n_checks++;
    if (dut.count !== 6'd1) begin
      n_fail++; $display("FAIL b2b_empty_count: count=%0d expected 1", dut.count);
    end
    re = 1'b1; tick(); re = 1'b0;
    n_checks++;
    if (data_out !== 64'h103 || empty !== 1'b1) begin
      n_fail++; $display("FAIL b2b_empty_tail: data_out=%h empty=%b expected 103/1", data_out, empty);
    end

    // Mid-occupancy: count stays 3 and order is preserved.
    fill(64'h200, 3);
    we = 1'b1; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 64'h203 + 64'(i);
      tick();
      exp_v = 64'h200 + 64'(i);
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++; $display("FAIL b2b_mid_read%0d: data_out=%h expected %h", i, data_out, exp_v);
      end
    end
    we = 1'b0; re = 1'b0;
    n_checks++;
    if (dut.count !== 6'd3) begin
      n_fail++; $display("FAIL b2b_mid_count: count=%0d expected 3", dut.count);
    end
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = 64'h204 + 64'(i);
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++; $display("FAIL b2b_mid_drain%0d: data_out=%h expected %h", i, data_out, exp_v);
      end
    end
    re = 1'b0;

    // From full: first edge is read-only, so word 0x400 is dropped.
    apply_reset();
    fill(64'h300, 32);
    we = 1'b1; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 64'h400 + 64'(i);
      tick();
      if (i == 0) begin
        n_checks++;
        if (dut.count !== 6'd31) begin
          n_fail++; $display("FAIL b2b_full_first: count=%0d expected 31", dut.count);
        end
      end
    end
    we = 1'b0; re = 1'b0;
    n_checks++;
    if (dut.count !== 6'd31 || data_out !== 64'h303) begin
      n_fail++; $display("FAIL b2b_full_count: count=%0d data_out=%h expected 31/303", dut.count, data_out);
    end
    re = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick();
      exp_v = (i < 28) ? 64'h304 + 64'(i) : 64'h401 + 64'(i - 28);
      n_checks++;
      if (data_out !== exp_v) begin
        n_fail++; $display("FAIL b2b_full_drain%0d: data_out=%h expected %h", i, data_out, exp_v);
      end
    end
    re = 1'b0;
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL b2b_full_empty: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    fill(64'h500, 11);
    re = 1'b1; tick(); re = 1'b0;
    n_checks++;
    if (dut.count !== 6'd10 || data_out !== 64'h500) begin
      n_fail++; $display("FAIL arst_setup: count=%0d data_out=%h expected 10/500", dut.count, data_out);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dut.count !== 6'd0 || dut.write_ptr !== 5'd0 || dut.read_ptr !== 5'd0 ||
        data_out !== 64'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL arst_immediate: count=%0d wptr=%0d rptr=%0d data_out=%h empty=%b full=%b expected all 0, empty=1",
                         dut.count, dut.write_ptr, dut.read_ptr, data_out, empty, full);
    end
    we = 1'b1; re = 1'b1; data_in = 64'h999;
    tick();
    n_checks++;
    if (dut.count !== 6'd0 || dut.write_ptr !== 5'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL arst_held: count=%0d wptr=%0d empty=%b expected 0/0/1", dut.count, dut.write_ptr, empty);
    end
    we = 1'b0; re = 1'b0;
    rst = 1'b1;
    we = 1'b1; data_in = 64'h77; tick(); we = 1'b0;
    re = 1'b1; tick(); re = 1'b0;
    n_checks++;
    if (data_out !== 64'h77 || empty !== 1'b1) begin
      n_fail++; $display("FAIL arst_first_after: data_out=%h empty=%b expected 77/1", data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_empty_read();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
